// File: rtl/vga_stream_decoder.sv
// VGA receive side: recovers pixel coordinates, checks line/frame timing,
// locks to the stream and reports the key-colour bounding box per frame.
module vga_stream_decoder #(
    parameter int         H_ACTIVE        = 640,
    parameter int         H_FRONT         = 16,
    parameter int         H_SYNC          = 96,
    parameter int         H_BACK          = 48,
    parameter int         V_ACTIVE        = 480,
    parameter int         V_FRONT         = 10,
    parameter int         V_SYNC          = 2,
    parameter int         V_BACK          = 33,
    parameter bit         SYNC_ACTIVE_LOW = 1'b1,
    parameter logic [7:0] KEY_R           = 8'd255,
    parameter logic [7:0] KEY_G           = 8'd255,
    parameter logic [7:0] KEY_B           = 8'd255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    input  logic       hor_sync,
    input  logic       ver_sync,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       pix_valid,
    output logic       locked,
    output logic       frame_done,
    output logic       obj_found,
    output logic [9:0] obj_x_min,
    output logic [9:0] obj_x_max,
    output logic [9:0] obj_y_min,
    output logic [9:0] obj_y_max,
    output logic       timing_err,
    output logic [7:0] err_count
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_TOT  = 10'(H_TOTAL);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SW   = 10'(H_SYNC);
    localparam logic [9:0] H_ST   = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_EN   = 10'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [9:0] V_ST   = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_EN   = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0] CMAX   = '1;

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        LOCKED
    } state_t;

    state_t     state_q, state_d, st_nxt;
    logic       hs_q, hs_d, vs_q, vs_d;
    logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [9:0] hw_q, hw_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       terr_q, terr_d;
    logic       pv_q, pv_d, fd_q, fd_d;
    logic [9:0] px_q, px_d, py_q, py_d;
    logic       found_q, found_d;
    logic [9:0] ox_min_q, ox_min_d, ox_max_q, ox_max_d;
    logic [9:0] oy_min_q, oy_min_d, oy_max_q, oy_max_d;
    logic       w_found_q, w_found_d;
    logic [9:0] wx_min_q, wx_min_d, wx_max_q, wx_max_d;
    logic [9:0] wy_min_q, wy_min_d, wy_max_q, wy_max_d;

    logic       hs_n, vs_n, hs_lead, hs_trail, vs_lead;
    logic [9:0] h_nxt, v_nxt, hw_nxt, x_nxt, y_nxt;
    logic       viol, err, in_act, valid, key_hit;

    // Sync normalised to active-high before edge detection
    assign hs_n     = hor_sync ^ SYNC_ACTIVE_LOW;
    assign vs_n     = ver_sync ^ SYNC_ACTIVE_LOW;
    assign hs_lead  = hs_n & ~hs_q;
    assign hs_trail = ~hs_n & hs_q;
    assign vs_lead  = vs_n & ~vs_q;

    assign h_nxt  = hs_lead ? '0 :
                    (h_cnt_q == H_TOT) ? H_TOT : h_cnt_q + 10'd1;
    assign v_nxt  = vs_lead ? '0 :
                    (hs_lead && v_cnt_q != CMAX) ? v_cnt_q + 10'd1 : v_cnt_q;
    assign hw_nxt = hs_lead ? 10'd1 :
                    (hs_n && hw_q != CMAX) ? hw_q + 10'd1 : hw_q;

    // Last clause catches a line running past H_TOTAL (missing hsync)
    assign viol = (hs_lead && h_cnt_q != H_LAST)
                | (hs_trail && hw_q != H_SW)
                | (vs_lead && v_cnt_q != V_LAST)
                | (!hs_lead && h_cnt_q == H_LAST);
    assign err  = viol && (state_q != SEARCH);

    assign x_nxt   = h_nxt - H_ST;
    assign y_nxt   = v_nxt - V_ST;
    assign in_act  = (h_nxt >= H_ST) && (h_nxt <= H_EN)
                  && (v_nxt >= V_ST) && (v_nxt <= V_EN);
    assign valid   = in_act && (st_nxt == LOCKED);
    assign key_hit = (red == KEY_R) && (green == KEY_G) && (blue == KEY_B);

    always_comb begin
        st_nxt = state_q;
        unique case (state_q)
            SEARCH:  if (vs_lead) st_nxt = ACQUIRE;
            ACQUIRE: if (err) st_nxt = SEARCH;
                     else if (vs_lead) st_nxt = LOCKED;
            LOCKED:  if (err) st_nxt = SEARCH;
            default: st_nxt = SEARCH;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        hw_d      = hw_q;
        err_cnt_d = err_cnt_q;
        terr_d    = 1'b0;
        pv_d      = 1'b0;
        fd_d      = 1'b0;
        px_d      = px_q;
        py_d      = py_q;
        found_d   = found_q;
        ox_min_d  = ox_min_q;
        ox_max_d  = ox_max_q;
        oy_min_d  = oy_min_q;
        oy_max_d  = oy_max_q;
        w_found_d = w_found_q;
        wx_min_d  = wx_min_q;
        wx_max_d  = wx_max_q;
        wy_min_d  = wy_min_q;
        wy_max_d  = wy_max_q;
        if (pix_en) begin
            state_d = st_nxt;
            hs_d    = hs_n;
            vs_d    = vs_n;
            h_cnt_d = h_nxt;
            v_cnt_d = v_nxt;
            hw_d    = hw_nxt;
            if (err) begin
                terr_d = 1'b1;
                if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end
            if (vs_lead) begin
                w_found_d = 1'b0;
                wx_min_d  = CMAX;
                wx_max_d  = '0;
                wy_min_d  = CMAX;
                wy_max_d  = '0;
            end
            if (valid) begin
                pv_d = 1'b1;
                px_d = x_nxt;
                py_d = y_nxt;
                if (key_hit) begin
                    w_found_d = 1'b1;
                    if (x_nxt < wx_min_d) wx_min_d = x_nxt;
                    if (x_nxt > wx_max_d) wx_max_d = x_nxt;
                    if (y_nxt < wy_min_d) wy_min_d = y_nxt;
                    if (y_nxt > wy_max_d) wy_max_d = y_nxt;
                end
                // Publish including this pixel's own contribution
                if (x_nxt == X_LAST && y_nxt == Y_LAST) begin
                    fd_d     = 1'b1;
                    found_d  = w_found_d;
                    ox_min_d = w_found_d ? wx_min_d : '0;
                    ox_max_d = w_found_d ? wx_max_d : '0;
                    oy_min_d = w_found_d ? wy_min_d : '0;
                    oy_max_d = w_found_d ? wy_max_d : '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SEARCH;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            hw_q      <= '0;
            err_cnt_q <= '0;
            terr_q    <= 1'b0;
            pv_q      <= 1'b0;
            fd_q      <= 1'b0;
            px_q      <= '0;
            py_q      <= '0;
            found_q   <= 1'b0;
            ox_min_q  <= '0;
            ox_max_q  <= '0;
            oy_min_q  <= '0;
            oy_max_q  <= '0;
            w_found_q <= 1'b0;
            wx_min_q  <= CMAX;
            wx_max_q  <= '0;
            wy_min_q  <= CMAX;
            wy_max_q  <= '0;
        end else begin
            state_q   <= state_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            hw_q      <= hw_d;
            err_cnt_q <= err_cnt_d;
            terr_q    <= terr_d;
            pv_q      <= pv_d;
            fd_q      <= fd_d;
            px_q      <= px_d;
            py_q      <= py_d;
            found_q   <= found_d;
            ox_min_q  <= ox_min_d;
            ox_max_q  <= ox_max_d;
            oy_min_q  <= oy_min_d;
            oy_max_q  <= oy_max_d;
            w_found_q <= w_found_d;
            wx_min_q  <= wx_min_d;
            wx_max_q  <= wx_max_d;
            wy_min_q  <= wy_min_d;
            wy_max_q  <= wy_max_d;
        end
    end

    assign pix_x      = px_q;
    assign pix_y      = py_q;
    assign pix_valid  = pv_q;
    assign locked     = (state_q == LOCKED);
    assign frame_done = fd_q;
    assign obj_found  = found_q;
    assign obj_x_min  = ox_min_q;
    assign obj_x_max  = ox_max_q;
    assign obj_y_min  = oy_min_q;
    assign obj_y_max  = oy_max_q;
    assign timing_err = terr_q;
    assign err_count  = err_cnt_q;
endmodule

// File: tb/tb_vga_stream_decoder.sv
// Scoreboard bench for vga_stream_decoder using a scaled-down raster
// (16x12 active) so whole frames fit in a short run.
module tb_vga_stream_decoder;
    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 12, VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int HOFF = HS + HB;
    localparam int VOFF = VS + VB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_en = 1'b0;
    logic       hor_sync = 1'b1;
    logic       ver_sync = 1'b1;
    logic [7:0] red = '0, green = '0, blue = '0;
    logic [9:0] pix_x, pix_y;
    logic       pix_valid, locked, frame_done, obj_found;
    logic [9:0] obj_x_min, obj_x_max, obj_y_min, obj_y_max;
    logic       timing_err;
    logic [7:0] err_count;

    vga_stream_decoder #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .hor_sync(hor_sync), .ver_sync(ver_sync),
        .red(red), .green(green), .blue(blue),
        .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .locked(locked), .frame_done(frame_done), .obj_found(obj_found),
        .obj_x_min(obj_x_min), .obj_x_max(obj_x_max),
        .obj_y_min(obj_y_min), .obj_y_max(obj_y_max),
        .timing_err(timing_err), .err_count(err_count)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic       f;
        logic [9:0] x0, x1, y0, y1;
    } frm_t;

    frm_t fq[$];
    int   eq[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   st = 0;
    int   exp_err = 0;
    bit   cur_expv = 1'b0;
    int   cur_x = 0, cur_y = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pix_valid"}, 32'(pix_valid), 0);
        chk({tag, "_pix_x"}, 32'(pix_x), 0);
        chk({tag, "_pix_y"}, 32'(pix_y), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
        chk({tag, "_obj_found"}, 32'(obj_found), 0);
        chk({tag, "_x_min"}, 32'(obj_x_min), 0);
        chk({tag, "_x_max"}, 32'(obj_x_max), 0);
        chk({tag, "_y_min"}, 32'(obj_y_min), 0);
        chk({tag, "_y_max"}, 32'(obj_y_max), 0);
        chk({tag, "_timing_err"}, 32'(timing_err), 0);
        chk({tag, "_err_count"}, 32'(err_count), 0);
    endtask

    // Monitor: compares every DUT response against queued expectations
    initial begin
        logic en_s;
        frm_t f;
        forever begin
            @(posedge clk);
            en_s = pix_en;
            #1;
            if (rst_n) begin
                if (en_s) begin
                    chk("pix_valid", 32'(pix_valid), 32'(cur_expv));
                    if (cur_expv && pix_valid) begin
                        chk("pix_x", 32'(pix_x), cur_x);
                        chk("pix_y", 32'(pix_y), cur_y);
                    end
                end else begin
                    chk("idle_pulses", {29'd0, pix_valid, frame_done, timing_err}, 0);
                end
                if (frame_done) begin
                    if (fq.size() == 0) begin
                        chk("frame_done_unexpected", 32'(frame_done), 0);
                    end else begin
                        f = fq.pop_front();
                        chk("obj_found", 32'(obj_found), 32'(f.f));
                        chk("obj_x_min", 32'(obj_x_min), 32'(f.x0));
                        chk("obj_x_max", 32'(obj_x_max), 32'(f.x1));
                        chk("obj_y_min", 32'(obj_y_min), 32'(f.y0));
                        chk("obj_y_max", 32'(obj_y_max), 32'(f.y1));
                    end
                end
                if (timing_err) begin
                    if (eq.size() == 0)
                        chk("timing_err_unexpected", 32'(timing_err), 0);
                    else
                        chk("err_count", 32'(err_count), eq.pop_front());
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic send_px(input bit hs, input bit vs, input logic [7:0] r,
                           input logic [7:0] g, input logic [7:0] b,
                           input bit ev, input int x, input int y);
        @(negedge clk);
        pix_en   = 1'b1;
        hor_sync = ~hs;
        ver_sync = ~vs;
        red      = r;
        green    = g;
        blue     = b;
        cur_expv = ev;
        cur_x    = x;
        cur_y    = y;
        @(negedge clk);
        pix_en = 1'b0;
    endtask

    task automatic violation();
        st = 0;
        if (exp_err < 255) exp_err++;
        eq.push_back(exp_err);
    endtask

    task automatic frame(input int short_l, input int rst_l,
                         input int ox0, input int ox1,
                         input int oy0, input int oy1,
                         input bit ef, input int ex0, input int ex1,
                         input int ey0, input int ey1);
        for (int v = 0; v < VT; v++) begin
            int len;
            len = (v == short_l) ? HT - 1 : HT;
            for (int h = 0; h < len; h++) begin
                bit act, ev;
                int x, y;
                logic [7:0] r, g, b;
                frm_t e;
                if (v == 0 && h == 0) st = (st == 0) ? 1 : 2;
                else if (h == 0 && v == short_l + 1 && st != 0) violation();
                act = h >= HOFF && h < HOFF + HA && v >= VOFF && v < VOFF + VA;
                x = h - HOFF;
                y = v - VOFF;
                if (!act || (x >= ox0 && x <= ox1 && y >= oy0 && y <= oy1)) begin
                    r = 8'hFF; g = 8'hFF; b = 8'hFF;
                end else if (x == 10 && y == 2) begin
                    r = 8'hFF; g = 8'hFE; b = 8'hFF;
                end else begin
                    r = 8'(x * 8); g = 8'(y * 8); b = 8'h40;
                end
                ev = (st == 2) && act;
                if (ev && x == HA - 1 && y == VA - 1) begin
                    e.f = ef;
                    e.x0 = 10'(ex0); e.x1 = 10'(ex1);
                    e.y0 = 10'(ey0); e.y1 = 10'(ey1);
                    fq.push_back(e);
                end
                send_px(h < HS, v < VS, r, g, b, ev, x, y);
                if (v == rst_l && h == HOFF + 3) begin
                    rst_n = 1'b0;
                    #1;
                    chk_zero("midrst");
                    st = 0;
                    exp_err = 0;
                    @(negedge clk);
                    rst_n = 1'b1;
                end
            end
        end
    endtask

    // Two short lines; the first has a 3-pixel hsync, one short of nominal
    task automatic mini_frame();
        for (int v = 0; v < 2; v++) begin
            for (int h = 0; h < 8; h++) begin
                if (v == 0 && h == 0) st = (st == 0) ? 1 : 2;
                else if (v == 0 && h == HS - 1 && st != 0) violation();
                send_px(h < ((v == 0) ? HS - 1 : HS), v == 0,
                        8'd0, 8'd0, 8'd0, 1'b0, 0, 0);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        frame(-1, -1, 5, 7, 4, 6, 1, 5, 7, 4, 6);
        chk("acq_locked", 32'(locked), 0);
        frame(-1, -1, 5, 7, 4, 6, 1, 5, 7, 4, 6);
        chk("lock_locked", 32'(locked), 1);
        chk("lock_err_count", 32'(err_count), 0);
        frame(-1, -1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        frame(-1, -1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        frame(-1, -1, 15, 15, 11, 11, 1, 15, 15, 11, 11);
        chk("corner_x_min", 32'(obj_x_min), 15);
        frame(5, -1, 5, 7, 4, 6, 1, 5, 7, 4, 6);
        chk("short_locked", 32'(locked), 0);
        chk("short_err_count", 32'(err_count), 1);
        chk("short_hold_x_min", 32'(obj_x_min), 15);
        chk("short_hold_found", 32'(obj_found), 1);
        frame(-1, -1, 5, 7, 4, 6, 1, 5, 7, 4, 6);
        chk("reacq_locked", 32'(locked), 0);
        frame(-1, -1, 2, 9, 3, 8, 1, 2, 9, 3, 8);
        chk("relock_locked", 32'(locked), 1);
        frame(-1, 8, 5, 7, 4, 6, 1, 5, 7, 4, 6);
        chk("post_rst_locked", 32'(locked), 0);
        frame(-1, -1, 5, 7, 4, 6, 1, 5, 7, 4, 6);
        frame(-1, -1, 1, 14, 0, 11, 1, 1, 14, 0, 11);
        chk("rst_relock_locked", 32'(locked), 1);
        for (int i = 0; i < 300; i++) mini_frame();
        repeat (4) @(negedge clk);
        chk("sat_err_count", 32'(err_count), 255);
        chk("sat_locked", 32'(locked), 0);
        chk("frame_q_drained", fq.size(), 0);
        chk("err_q_drained", eq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
